// File: rtl/quad_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quad_decoder: 2-flop synchronizer, per-channel debounce and quadrature step
// decoder. Define QUAD_ERR_EN to add the sticky err output.  Rev 1.0
// ----------------------------------------------------------------------------
module quad_decoder #(
  parameter int DB_CYCLES = 4,
  parameter int DBW       = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec
`ifdef QUAD_ERR_EN
  ,
  output logic err
`endif
);

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DBW-1:0] DB_LIM = DBW'(DB_CYCLES);

  state_t         state, state_nxt;
  logic           a_m, b_m, a_s, b_s, a_d, b_d;
  logic           a_st, b_st, a_st_nxt, b_st_nxt;
  logic [1:0]     pair_prev;
  logic [DBW-1:0] cnt_a, cnt_b, cnt_i;
  logic [DBW-1:0] cnt_a_nxt, cnt_b_nxt, cnt_i_nxt;
  logic [DBW:0]   db_a, db_b;
  logic           inc_nxt, dec_nxt, illegal;

  // Returns {load_stable, next_count} for one channel.
  function automatic logic [DBW:0] debounce(input logic s, input logic s_d,
                                            input logic st, input logic [DBW-1:0] cnt);
    logic [DBW-1:0] n;
    n = '0;
    if (s != st) n = (s != s_d) ? DBW'(1) : cnt + DBW'(1);
    if (n == DB_LIM) return {1'b1, {DBW{1'b0}}};
    return {1'b0, n};
  endfunction

  assign db_a    = debounce(a_s, a_d, a_st, cnt_a);
  assign db_b    = debounce(b_s, b_d, b_st, cnt_b);
  assign illegal = ((pair_prev ^ {a_st, b_st}) == 2'b11);

  always_comb begin
    state_nxt = state;
    a_st_nxt  = a_st;
    b_st_nxt  = b_st;
    cnt_a_nxt = '0;
    cnt_b_nxt = '0;
    cnt_i_nxt = '0;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    case (state)
      INIT: begin
        a_st_nxt = a_s;
        b_st_nxt = b_s;
        if ({a_s, b_s} == {a_d, b_d}) begin
          cnt_i_nxt = cnt_i + DBW'(1);
          if (cnt_i_nxt == DB_LIM) begin
            state_nxt = RUN;
            cnt_i_nxt = '0;
          end
        end
      end
      RUN: begin
        cnt_a_nxt = db_a[DBW-1:0];
        cnt_b_nxt = db_b[DBW-1:0];
        if (db_a[DBW]) a_st_nxt = a_s;
        if (db_b[DBW]) b_st_nxt = b_s;
        // Gray sequence 00 -> 01 -> 11 -> 10 is the forward direction.
        case ({pair_prev, a_st, b_st})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: inc_nxt = 1'b1;
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dec_nxt = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {a_m, b_m, a_s, b_s, a_d, b_d} <= 6'b0;
      a_st      <= 1'b0;
      b_st      <= 1'b0;
      pair_prev <= 2'b00;
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_i     <= '0;
      state     <= INIT;
      inc       <= 1'b0;
      dec       <= 1'b0;
    end else begin
      a_m       <= a;
      b_m       <= b;
      a_s       <= a_m;
      b_s       <= b_m;
      a_d       <= a_s;
      b_d       <= b_s;
      a_st      <= a_st_nxt;
      b_st      <= b_st_nxt;
      pair_prev <= {a_st, b_st};
      cnt_a     <= cnt_a_nxt;
      cnt_b     <= cnt_b_nxt;
      cnt_i     <= cnt_i_nxt;
      state     <= state_nxt;
      inc       <= inc_nxt;
      dec       <= dec_nxt;
    end
  end

`ifdef QUAD_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state == RUN && illegal) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_quad_decoder: directed stimulus against a history-window model of
// quad_decoder, plus literal latency/count checks.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a   = 1'b1;
  logic b   = 1'b1;
  logic inc, dec;
`ifdef QUAD_ERR_EN
  logic err;
`endif

  quad_decoder #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .inc (inc),
    .dec (dec)
`ifdef QUAD_ERR_EN
    ,
    .err (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_inc = 0;
  int n_dec = 0;
  int pos   = 8;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Position along the Gray cycle 00,01,11,10.
  function automatic int gp(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Model: synchronizer as a 2-stage delay, stability judged over a window
  // of the synchronized history, step direction from Gray-position distance.
  logic [1:0] m_meta, m_sync, m_st, m_stp, nst;
  logic       m_run, e_inc, e_dec, e_err;
  logic [1:0] hist[$];
  int         d;
  bit         same;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_meta = 2'b00; m_sync = 2'b00; m_st = 2'b00; m_stp = 2'b00;
      m_run = 1'b0; e_inc = 1'b0; e_dec = 1'b0; e_err = 1'b0;
      hist.delete();
      hist.push_back(2'b00);
    end else begin
      hist.push_back(m_sync);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      d = (gp(m_st) - gp(m_stp)) & 3;
      e_inc = m_run && (d == 1);
      e_dec = m_run && (d == 3);
      if (m_run && d == 2) e_err = 1'b1;
      nst = m_st;
      if (!m_run) begin
        nst = m_sync;
        if (hist.size() >= DB + 1) begin
          same = 1'b1;
          for (int i = 0; i <= DB; i++)
            if (hist[hist.size() - 1 - i] != m_sync) same = 1'b0;
          if (same) m_run = 1'b1;
        end
      end else begin
        for (int c = 0; c < 2; c++) begin
          same = (m_sync[c] != m_st[c]);
          for (int i = 0; i < DB; i++)
            if (hist[hist.size() - 1 - i][c] != m_sync[c]) same = 1'b0;
          if (same) nst[c] = m_sync[c];
        end
      end
      m_stp  = m_st;
      m_st   = nst;
      m_sync = m_meta;
      m_meta = {a, b};
    end
  end

  // Every-cycle comparison plus the downstream mod-10 position counter.
  always @(negedge clk) begin
    check("inc", {31'b0, inc}, {31'b0, e_inc});
    check("dec", {31'b0, dec}, {31'b0, e_dec});
    check("inc_dec_exclusive", {31'b0, inc & dec}, 32'd0);
`ifdef QUAD_ERR_EN
    check("err", {31'b0, err}, {31'b0, e_err});
`endif
    if (!rst)     pos = 8;
    else if (inc) pos = (pos + 1) % 10;
    else if (dec) pos = (pos + 9) % 10;
    if (inc) n_inc++;
    if (dec) n_dec++;
  end

  task automatic do_reset(input logic va, input logic vb);
    @(posedge clk); #2;
    rst = 1'b0;
    a = va;
    b = vb;
    #1;
    check("reset_inc", {31'b0, inc}, 32'd0);
    check("reset_dec", {31'b0, dec}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic hold(input logic va, input logic vb, input int cycles);
    a = va;
    b = vb;
    repeat (cycles) @(negedge clk);
  endtask

  int bi, bd;

  initial begin
    // Reset with 11 held, then release: INIT -> RUN with no pulse.
    repeat (3) @(negedge clk);
    check("por_inc", {31'b0, inc}, 32'd0);
    check("por_dec", {31'b0, dec}, 32'd0);
    bi = n_inc; bd = n_dec;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("release_11_no_inc", n_inc - bi, 0);
    check("release_11_no_dec", n_dec - bd, 0);

    // Clean forward step: pulse exactly 7 cycles after the edge.
    do_reset(1'b0, 1'b0);
    bi = n_inc;
    b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("latency_k%0d", k), {31'b0, inc}, (k == 7) ? 32'd1 : 32'd0);
    end
    hold(1'b1, 1'b1, 12);
    check("fwd_two_steps", n_inc - bi, 2);
    check("mod10_wrap", pos, 0);

    // Reverse sequence: four dec pulses, no inc.
    do_reset(1'b0, 1'b0);
    bi = n_inc; bd = n_dec;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    repeat (10) @(negedge clk);
    check("rev_dec_count", n_dec - bd, 4);
    check("rev_inc_count", n_inc - bi, 0);

    // 3-cycle glitches on a are rejected; stable pair stays 00.
    bi = n_inc; bd = n_dec;
    for (int g = 0; g < 4; g++) begin
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 3);
    end
    repeat (15) @(negedge clk);
    check("glitch_no_inc", n_inc - bi, 0);
    check("glitch_no_dec", n_dec - bd, 0);
    hold(1'b0, 1'b1, 12);
    check("after_glitch_fwd", n_inc - bi, 1);
    check("after_glitch_no_dec", n_dec - bd, 0);

    // Illegal 00 -> 11 jump: no pulse, sticky err.
    do_reset(1'b0, 1'b0);
    bi = n_inc; bd = n_dec;
    hold(1'b1, 1'b1, 15);
    check("illegal_no_inc", n_inc - bi, 0);
    check("illegal_no_dec", n_dec - bd, 0);
`ifdef QUAD_ERR_EN
    check("illegal_err_set", {31'b0, err}, 32'd1);
    repeat (10) @(negedge clk);
    check("illegal_err_held", {31'b0, err}, 32'd1);
`endif

    // Reset mid-debounce drops the pending step.
    bi = n_inc; bd = n_dec;
    hold(1'b0, 1'b1, 3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_inc", {31'b0, inc}, 32'd0);
    check("mid_rst_dec", {31'b0, dec}, 32'd0);
`ifdef QUAD_ERR_EN
    check("mid_rst_err", {31'b0, err}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_no_inc", n_inc - bi, 0);
    check("mid_rst_no_dec", n_dec - bd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
